// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter with a small byte FIFO between the CPU write strobe and the serial line.
// Outputs uart_tx, uart_full and uart_busy all come straight from flops.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_en,
    input  logic [7:0] uart_data,
    output logic       uart_tx,
    output logic       uart_full,
    output logic       uart_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_full;
    logic             r_busy;

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tx;

    logic             w_push;
    logic             w_pop;
    logic             w_cnt_last;
    logic [PTR_W:0]   w_count_next;
    logic [7:0]       w_shift_next;
    logic [2:0]       w_bit_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_tx_next;

    // The full flag is registered, so a push while full is dropped even if a pop shares the edge.
    assign w_push     = uart_en & ~r_full;
    assign w_cnt_last = (r_cnt == CNT_LAST);

    // FIFO occupancy after this edge's push/pop.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + (PTR_W + 1)'(1);
            2'b01:   w_count_next = r_count - (PTR_W + 1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= uart_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_next = S_START;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_START: begin
                if (w_cnt_last) begin
                    w_state_next = S_DATA;
                end else begin
                    w_state_next = S_START;
                end
            end
            S_DATA: begin
                if (w_cnt_last && (r_bit == 3'd7)) begin
                    w_state_next = S_STOP;
                end else begin
                    w_state_next = S_DATA;
                end
            end
            S_STOP: begin
                if (w_cnt_last && (r_count != '0)) begin
                    w_state_next = S_START;
                end else if (w_cnt_last) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_STOP;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM datapath: pop, shift, counters and the next line level (registered below).
    always_comb begin
        w_pop        = 1'b0;
        w_shift_next = r_shift;
        w_bit_next   = r_bit;
        w_cnt_next   = r_cnt;
        w_tx_next    = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                w_bit_next = 3'd0;
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_shift_next = r_mem[r_rd_ptr];
                    w_tx_next    = 1'b0;
                end else begin
                    w_tx_next = 1'b1;
                end
            end
            S_START: begin
                if (w_cnt_last) begin
                    w_cnt_next = '0;
                    w_bit_next = 3'd0;
                    w_tx_next  = r_shift[0];
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                    w_tx_next  = 1'b0;
                end
            end
            S_DATA: begin
                if (w_cnt_last && (r_bit == 3'd7)) begin
                    w_cnt_next = '0;
                    w_bit_next = 3'd0;
                    w_tx_next  = 1'b1;
                end else if (w_cnt_last) begin
                    w_cnt_next   = '0;
                    w_bit_next   = r_bit + 3'd1;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_tx_next    = r_shift[1];
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                    w_tx_next  = r_shift[0];
                end
            end
            S_STOP: begin
                if (w_cnt_last && (r_count != '0)) begin
                    w_cnt_next   = '0;
                    w_pop        = 1'b1;
                    w_shift_next = r_mem[r_rd_ptr];
                    w_tx_next    = 1'b0;
                end else if (w_cnt_last) begin
                    w_cnt_next = '0;
                    w_tx_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                    w_tx_next  = 1'b1;
                end
            end
            default: begin
                w_cnt_next = '0;
                w_bit_next = 3'd0;
                w_tx_next  = 1'b1;
            end
        endcase
    end

    // Datapath and status registers; status is decoded from next-state values so it tracks the registers exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= 8'h00;
            r_bit   <= 3'd0;
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_full  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_shift <= w_shift_next;
            r_bit   <= w_bit_next;
            r_cnt   <= w_cnt_next;
            r_tx    <= w_tx_next;
            r_full  <= (w_count_next == COUNT_FULL);
            r_busy  <= (w_state_next != S_IDLE) || (w_count_next != '0);
        end
    end

    assign uart_tx   = r_tx;
    assign uart_full = r_full;
    assign uart_busy = r_busy;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
UART transmitter peripheral that consumes the CPU's byte-write strobe (uart_en plus data byte) and serialises bytes onto a single TX line as 8N1 frames. A small FIFO decouples CPU store bursts from the slow serial line. Sits beside the riscv core at top level; the core's uart_en output drives this block's write strobe.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal values >= 2.
FIFO_DEPTH, 4, byte FIFO entries; power of 2, >= 2.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
uart_en  input  1  write strobe from CPU, one byte per high cycle
uart_data  input  8  byte to transmit, sampled with uart_en
uart_tx  output  1  serial line, idle high
uart_full  output  1  FIFO holds FIFO_DEPTH bytes
uart_busy  output  1  FIFO not empty or frame in progress

Behaviour:
- Reset (reset=0, async): uart_tx=1, uart_full=0, uart_busy=0, FIFO empty, read/write pointers=0, bit/cycle counters=0, FSM=IDLE. Reset mid-frame aborts the frame; line returns high immediately; queued bytes are discarded.
- Push: at a rising edge with uart_en=1 and uart_full=0 (value before the edge), uart_data is written at wr_ptr; wr_ptr increments modulo FIFO_DEPTH. With uart_full=1 the byte is dropped silently; no state changes.
- Pop: the FSM pops head into the shift register; rd_ptr increments modulo FIFO_DEPTH.
- Same-edge push and pop: both happen; count unchanged. When full, a push is dropped even if a pop occurs on that edge.
- uart_full = (count == FIFO_DEPTH); uart_busy = (FSM != IDLE) || (count != 0); both are decoded from registers with no combinational path from inputs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If count != 0, pop and go to START; uart_tx is registered low on that same edge.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: uart_tx = shift[0] for CLKS_PER_BIT cycles per bit. Bits go LSB first; after bit 7 go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. At the end, if count != 0, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Latency: a byte accepted at edge E into an empty FIFO with FSM in IDLE drives uart_tx low after edge E+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles. The cycle counter runs 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
- uart_tx is driven directly from a flop; no glitches.

Test Plan:
- Reset: hold reset=0 for 5 cycles while toggling uart_en -> uart_tx=1, uart_full=0, uart_busy=0. After release, no frame starts.
- Single byte, CLKS_PER_BIT=4: write 0xA5 at edge E.
  - uart_tx goes low at E+1 and holds for 4 cycles.
  - Data bits, 4 cycles each: 1,0,1,0,0,1,0,1.
  - Stop bit is high for 4 cycles.
  - uart_busy drops at E+41.
- Back-to-back: write 0x00 then 0xFF on consecutive cycles, CLKS_PER_BIT=4.
  - Two frames, 80 cycles total, start bit of frame 2 immediately after stop of frame 1.
  - Line pattern: 0, 8×0, 1, 0, 8×1, 1.
- Overflow, FIFO_DEPTH=4: write 0x01..0x06 on 6 consecutive edges E..E+5.
  - uart_full=1 after E+4.
  - 0x06 is dropped.
  - Exactly 0x01..0x05 are transmitted in order.
  - uart_full clears after the second pop.
- Reset mid-frame: assert reset during DATA bit 3 of 0x3C with 2 bytes queued.
  - uart_tx=1 with no clock edge needed; uart_busy=0.
  - After release, nothing is transmitted.
- Pointer wrap: write 10 bytes 0x10..0x19, each issued when uart_full=0 -> all 10 received in order, no loss or duplication, and the pointers wrap twice.
